// File: rtl/wb_mailbox.sv
// -----------------------------------------------------------------------------
// wb_mailbox
//
// Wishbone-classic slave that a CPU under test uses to report its result and to
// stream console text out to the test harness.
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 STATUS  W: report result (byte 0).  R: {20'b0, overflow, empty, done, pass, exit_code}
//   0x4 CONSOLE W: push byte 0 into the console FIFO.  R: 0
//   0x8 LEVEL   R: number of bytes queued in the console FIFO
//   0xC CYCLES  R: free-running cycle count (only with WB_MAILBOX_CYCLE_CNT_EN), else 0
//
// Optional feature macro: WB_MAILBOX_CYCLE_CNT_EN adds a 32-bit cycle counter
// that freezes once done is set.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i   Wishbone inputs
//   wb_dat_o, wb_ack_o         Wishbone read data and acknowledge (registered)
//   done, pass, exit_code      test result
//   char_valid, char_data, char_ready   console drain port (valid/ready)
// -----------------------------------------------------------------------------
module wb_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        done,
    output logic        pass,
    output logic [7:0]  exit_code,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(FIFO_DEPTH);

    // Bus-side state: the request is latched at the request edge and committed
    // at the end of the ack cycle, but only if the master still holds cyc.
    logic          armed_r;
    logic          ack_r;
    logic [31:0]   dat_r;
    logic          we_r;
    logic          sel0_r;
    logic [1:0]    off_r;
    logic [7:0]    wdat_r;

    logic          done_r;
    logic          pass_r;
    logic [7:0]    exit_r;
    logic          ovf_r;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          req_s;
    logic          commit_s;
    logic          status_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic [31:0]   rdata_s;
    logic [31:0]   cyc_cnt_s;
    logic          unused_s;

    // armed_r blocks an access still held across reset release from being
    // acked: a new request is only taken after the bus has been seen idle.
    assign req_s = wb_cyc_i & wb_stb_i & armed_r & ~ack_r &
                   (wb_adr_i[31:4] == BASE_ADDR[31:4]);

    assign commit_s    = ack_r & wb_cyc_i & we_r & sel0_r;
    assign status_wr_s = commit_s & (off_r == 2'd0) & ~done_r;
    assign push_s      = commit_s & (off_r == 2'd1);

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == CNT_DEPTH);
    assign pop_s     = ~empty_s & char_ready;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;

    // Valid/data come only from registered FIFO state, so a push shows up on
    // char_valid one cycle later.
    assign char_valid = ~empty_s;
    assign char_data  = empty_s ? 8'h00 : mem_r[rd_ptr_r];

    assign wb_ack_o  = ack_r;
    assign wb_dat_o  = dat_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign exit_code = exit_r;

    assign unused_s = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

`ifdef WB_MAILBOX_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_r;

    // Free-running cycle counter, frozen once the result has been reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= 32'd0;
        end else if (!done_r) begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign cyc_cnt_s = cyc_cnt_r;
`else
    assign cyc_cnt_s = 32'h0000_0000;
`endif

    // Register read multiplexer, selected by the live word offset.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wb_adr_i[3:2])
            2'd0:    rdata_s = {20'h0_0000, ovf_r, empty_s, done_r, pass_r, exit_r};
            2'd1:    rdata_s = 32'h0000_0000;
            2'd2:    rdata_s = {{(32 - CW){1'b0}}, count_r};
            2'd3:    rdata_s = cyc_cnt_s;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake, result registers and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r  <= 1'b0;
            ack_r    <= 1'b0;
            dat_r    <= 32'h0000_0000;
            we_r     <= 1'b0;
            sel0_r   <= 1'b0;
            off_r    <= 2'd0;
            wdat_r   <= 8'h00;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            exit_r   <= 8'h00;
            ovf_r    <= 1'b0;
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (!(wb_cyc_i && wb_stb_i)) begin
                armed_r <= 1'b1;
            end
            ack_r <= req_s;
            dat_r <= (req_s && !wb_we_i) ? rdata_s : 32'h0000_0000;
            if (req_s) begin
                we_r   <= wb_we_i;
                sel0_r <= wb_sel_i[0];
                off_r  <= wb_adr_i[3:2];
                wdat_r <= wb_dat_i[7:0];
            end
            if (status_wr_s) begin
                done_r <= 1'b1;
                pass_r <= (wdat_r == 8'h01);
                exit_r <= wdat_r;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdat_r;
        end
    end

endmodule

// File: tb/tb_wb_mailbox.sv
`timescale 1ns/1ps
module tb_wb_mailbox;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        done;
    logic        pass;
    logic [7:0]  exit_code;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;

    int tests = 0;
    int fails = 0;
    logic        last_ack;
    logic [31:0] rd_val;
    logic [31:0] rd_val2;
    int          ack_seen;

    wb_mailbox dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .done(done), .pass(pass), .exit_code(exit_code),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        last_ack = wb_ack_o;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_adr_i = a; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        last_ack = wb_ack_o;
        d = wb_dat_o;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        char_ready = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        check("rst_done_pass", {30'b0, done, pass}, 32'h0);
        check("rst_exit", {24'b0, exit_code}, 32'h0);
        check("rst_char", {23'b0, char_valid, char_data}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass report, with one console byte queued so STATUS.empty is 0
        wb_write(32'h0000_1004, 32'h0000_005A, 4'h1);
        check("push_ack", {31'b0, last_ack}, 32'h1);
        check("push_valid", {31'b0, char_valid}, 32'h1);
        wb_adr_i = 32'h0000_1000; wb_dat_i = 32'h0000_0001; wb_sel_i = 4'h1;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #1;
        check("ack_not_early", {31'b0, wb_ack_o}, 32'h0);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'b0, wb_ack_o}, 32'h1);
        @(posedge clk); #1;
        bus_idle();
        check("ack_drop", {31'b0, wb_ack_o}, 32'h0);
        check("dat_idle_zero", wb_dat_o, 32'h0);
        check("pass_result", {22'b0, done, pass, exit_code}, 32'h301);
        wb_read(32'h0000_1000, rd_val);
        check("status_pass_rd", rd_val, 32'h0000_0301);
        wb_read(32'h0000_1004, rd_val);
        check("console_rd_zero", rd_val, 32'h0);

        // Failure code then pass: sticky
        do_reset();
        wb_write(32'h0000_1000, 32'h0000_00FF, 4'h1);
        wb_write(32'h0000_1000, 32'h0000_0001, 4'h1);
        check("sticky_ack", {31'b0, last_ack}, 32'h1);
        check("sticky_result", {22'b0, done, pass, exit_code}, 32'h2FF);
        wb_read(32'h0000_1000, rd_val);
        check("status_fail_rd", rd_val, 32'h0000_06FF);

        // Other failure code
        do_reset();
        wb_write(32'h0000_1000, 32'h1234_5637, 4'hF);
        check("other_code", {22'b0, done, pass, exit_code}, 32'h237);

        // Ignored writes: sel[0]=0, LEVEL, CYCLES, and abandoned access
        do_reset();
        wb_write(32'h0000_1000, 32'h0000_0001, 4'hE);
        check("sel0_ack", {31'b0, last_ack}, 32'h1);
        check("sel0_ignored", {31'b0, done}, 32'h0);
        wb_write(32'h0000_1008, 32'h0000_0001, 4'hF);
        wb_write(32'h0000_100C, 32'h0000_0001, 4'hF);
        check("level_wr_ack", {31'b0, last_ack}, 32'h1);
        wb_read(32'h0000_1008, rd_val);
        check("level_wr_ignored", rd_val, 32'h0);
        wb_adr_i = 32'h0000_1000; wb_dat_i = 32'h0000_0001; wb_sel_i = 4'h1;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        check("abandon_no_effect", {31'b0, done}, 32'h0);

        // Out-of-window address: no ack for 10 cycles
        ack_seen = 0;
        wb_adr_i = 32'h0000_1020; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) ack_seen++;
        end
        bus_idle();
        check("bad_addr_no_ack", ack_seen, 32'd0);

        // 17 pushes into 16-deep FIFO with no drain
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wb_write(32'h0000_1004, 32'h0000_0041 + i, 4'h1);
        end
        check("ovf_ack", {31'b0, last_ack}, 32'h1);
        wb_read(32'h0000_1008, rd_val);
        check("level_full", rd_val, 32'd16);
        wb_read(32'h0000_1000, rd_val);
        check("status_ovf", rd_val, 32'h0000_0800);
        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_order", {23'b0, char_valid, char_data}, 32'h100 + 32'h41 + i);
            @(posedge clk); #1;
        end
        char_ready = 1'b0;
        check("drain_empty", {31'b0, char_valid}, 32'h0);

        // Push into a full FIFO with a pop in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wb_write(32'h0000_1004, 32'h0000_0041 + i, 4'h1);
        end
        wb_adr_i = 32'h0000_1004; wb_dat_i = 32'h0000_0051; wb_sel_i = 4'h1;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        bus_idle();
        wb_read(32'h0000_1008, rd_val);
        check("level_push_pop", rd_val, 32'd16);
        wb_read(32'h0000_1000, rd_val);
        check("no_ovf_push_pop", rd_val, 32'h0);
        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_after_pp", {24'b0, char_data}, 32'h42 + i);
            @(posedge clk); #1;
        end
        char_ready = 1'b0;
        check("drain_pp_empty", {31'b0, char_valid}, 32'h0);

        // Reset asserted in the ack cycle of an access
        wb_write(32'h0000_1004, 32'h0000_0063, 4'h1);
        wb_write(32'h0000_1000, 32'h0000_0001, 4'h1);
        wb_adr_i = 32'h0000_1000; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack_dat", {wb_dat_o[30:0], wb_ack_o}, 32'h0);
        check("midrst_result", {22'b0, done, pass, exit_code}, 32'h0);
        check("midrst_char", {23'b0, char_valid, char_data}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) ack_seen++;
        end
        bus_idle();
        check("midrst_no_ack", ack_seen, 32'd0);
        @(posedge clk); #1;
        wb_read(32'h0000_1008, rd_val);
        check("midrst_fifo_clear", rd_val, 32'd0);

        // Cycle counter window
        do_reset();
`ifdef WB_MAILBOX_CYCLE_CNT_EN
        wb_read(32'h0000_100C, rd_val);
        repeat (8) @(posedge clk);
        #0;
        wb_read(32'h0000_100C, rd_val2);
        check("cyc_delta", rd_val2 - rd_val, 32'd10);
        wb_write(32'h0000_1000, 32'h0000_0001, 4'h1);
        wb_read(32'h0000_100C, rd_val);
        repeat (5) @(posedge clk);
        #0;
        wb_read(32'h0000_100C, rd_val2);
        check("cyc_frozen", rd_val2, rd_val);
`else
        wb_read(32'h0000_100C, rd_val);
        check("cyc_absent", rd_val, 32'h0);
        check("cyc_absent_ack", {31'b0, last_ack}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
